// File: rtl/ccff_stream_loader.sv
// Bitstream loader: takes configuration bytes over valid/ready and serializes them MSB-first
// onto the fabric configuration chain, generating prog_clk and the cfg_set pulse.
module ccff_stream_loader #(
  parameter int unsigned BITSTREAM_LEN = 1024,
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SET_CYCLES    = 4,
  parameter int unsigned CNT_W         = $clog2(BITSTREAM_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ccff_head,
  output logic       prog_clk,
  output logic       cfg_set,
  output logic       busy,
  output logic       done
);

  // One phase counter serves both the SET hold time and the prog_clk half periods.
  localparam int unsigned DivMax = (CLK_DIV > SET_CYCLES) ? CLK_DIV : SET_CYCLES;
  localparam int unsigned DivW   = $clog2(DivMax + 1);

  localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  SetLast = DivW'(SET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LenC    = CNT_W'(BITSTREAM_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StSet,
    StLoad,
    StShiftLo,
    StShiftHi,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] bit_cnt_inc;
  logic [7:0]       shreg_q, shreg_d;

  logic byte_ready_q, byte_ready_d;
  logic ccff_head_q, ccff_head_d;
  logic prog_clk_q, prog_clk_d;
  logic cfg_set_q, cfg_set_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Saturating so a stray extra high phase can never wrap the count.
  assign bit_cnt_inc = (bit_cnt_q == LenC) ? bit_cnt_q : bit_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StSet;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      StSet: begin
        if (div_cnt_q == SetLast) begin
          state_d   = StLoad;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      StLoad: begin
        if (byte_valid && byte_ready_q) begin
          shreg_d   = byte_data;
          bit_idx_d = 3'd7;
          div_cnt_d = '0;
          state_d   = StShiftLo;
        end
      end

      StShiftLo: begin
        if (div_cnt_q == DivLast) begin
          state_d   = StShiftHi;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      StShiftHi: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_inc;
          // A partial final byte ends here too; its unused low bits are simply dropped.
          if (bit_cnt_inc == LenC) begin
            state_d = StDone;
          end else if (bit_idx_q == 3'd0) begin
            state_d = StLoad;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
            shreg_d   = {shreg_q[6:0], 1'b0};
            state_d   = StShiftLo;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each is a clean flop output.
  always_comb begin
    byte_ready_d = (state_d == StLoad);
    prog_clk_d   = (state_d == StShiftHi);
    cfg_set_d    = (state_d == StSet);
    done_d       = (state_d == StDone);
    busy_d       = (state_d != StIdle) && (state_d != StDone);
    ccff_head_d  = ((state_d == StShiftLo) || (state_d == StShiftHi)) ? shreg_d[7] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      bit_idx_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      byte_ready_q <= 1'b0;
      ccff_head_q  <= 1'b0;
      prog_clk_q   <= 1'b0;
      cfg_set_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_idx_q    <= bit_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      byte_ready_q <= byte_ready_d;
      ccff_head_q  <= ccff_head_d;
      prog_clk_q   <= prog_clk_d;
      cfg_set_q    <= cfg_set_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign ccff_head  = ccff_head_q;
  assign prog_clk   = prog_clk_q;
  assign cfg_set    = cfg_set_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed bench for ccff_stream_loader: 20-bit bitstreams, stalls, mid-load reset, restart.
module tb_ccff_stream_loader;

  localparam int unsigned Len    = 20;
  localparam int unsigned Div    = 2;
  localparam int unsigned SetCyc = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       ccff_head;
  logic       prog_clk;
  logic       cfg_set;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  // Free-running monitors; the run task works with deltas against their values.
  int          hs_cnt   = 0;
  int          rise_cnt = 0;
  int          ovl_cnt  = 0;
  logic [63:0] chain    = '0;

  ccff_stream_loader #(
    .BITSTREAM_LEN(Len),
    .CLK_DIV      (Div),
    .SET_CYCLES   (SetCyc)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .ccff_head (ccff_head),
    .prog_clk  (prog_clk),
    .cfg_set   (cfg_set),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && byte_valid && byte_ready) hs_cnt <= hs_cnt + 1;
  always @(posedge clk) if (cfg_set && prog_clk) ovl_cnt <= ovl_cnt + 1;

  always @(posedge prog_clk) begin
    chain    <= {chain[62:0], ccff_head};
    rise_cnt <= rise_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int outs();
    return int'({byte_ready, ccff_head, prog_clk, cfg_set, busy, done});
  endfunction

  // Start a load one edge after the call and feed three bytes. stall drops byte_valid for that
  // many cycles while waiting for the second byte; abort pulls reset in the 2nd byte's high phase.
  task automatic run_load(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int stall, input bit abort,
                          input int exp_bits, input int exp_cyc);
    logic [7:0] bytes [3];
    int base_hs, base_rise, base_ovl, hs;
    int cyc, set_first, set_cnt, stall_left, stall_seen, stall_bad;
    bit got;
    bytes[0]   = b0;
    bytes[1]   = b1;
    bytes[2]   = b2;
    base_hs    = hs_cnt;
    base_rise  = rise_cnt;
    base_ovl   = ovl_cnt;
    cyc        = 0;
    set_first  = -1;
    set_cnt    = 0;
    stall_left = stall;
    stall_seen = 0;
    stall_bad  = 0;
    got        = 1'b0;
    @(posedge clk);
    #1;
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = bytes[0];
    while (cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == 20);  // stray pulse mid-shift must be ignored
      if (cyc == 1) begin
        check({tag, " done_clear"}, int'(done), 0);
        check({tag, " busy_on"}, int'(busy), 1);
      end
      if (cfg_set) begin
        set_cnt++;
        if (set_first < 0) set_first = cyc;
      end
      hs = hs_cnt - base_hs;
      byte_data = (hs < 3) ? bytes[hs] : 8'h00;
      if (abort && hs == 2 && prog_clk) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst_outs"}, outs(), 0);
        break;
      end
      if (hs == 1 && byte_ready && stall_left > 0) begin
        byte_valid = 1'b0;
        stall_left--;
        stall_seen++;
        if (prog_clk) stall_bad++;
      end else begin
        byte_valid = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (abort) begin
      repeat (3) @(posedge clk);
      #1;
      check({tag, " rst_hold"}, outs(), 0);
      base_rise = rise_cnt;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check({tag, " idle_after_rst"}, outs() | (rise_cnt - base_rise), 0);
    end else begin
      check({tag, " done_seen"}, int'(got), 1);
      check({tag, " cycles"}, cyc, exp_cyc);
      check({tag, " bits"}, int'(chain[19:0]), exp_bits);
      check({tag, " rises"}, rise_cnt - base_rise, 20);
      check({tag, " handshakes"}, hs_cnt - base_hs, 3);
      check({tag, " set_first"}, set_first, 1);
      check({tag, " set_len"}, set_cnt, 4);
      check({tag, " set_overlap"}, ovl_cnt - base_ovl, 0);
      check({tag, " stall_len"}, stall_seen, stall);
      check({tag, " stall_quiet"}, stall_bad, 0);
      check({tag, " done_outs"}, outs(), 1);
    end
  endtask

  initial begin
    int nz, base_rise;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    rst_n     = 1'b1;
    nz        = 0;
    base_rise = rise_cnt;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (outs() != 0) nz++;
    end
    check("idle_outs", nz, 0);
    check("idle_rises", rise_cnt - base_rise, 0);

    // 1010_0101_0011_1100_1111; 88 = 4 set + 1 start + 3 loads + 20*4 shift
    run_load("basic", 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 'hA53CF, 88);
    run_load("stall", 8'hA5, 8'h3C, 8'hF0, 10, 1'b0, 'hA53CF, 98);
    run_load("abort", 8'hA5, 8'h3C, 8'hF0, 0, 1'b1, 0, 0);
    run_load("fresh", 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 'hA53CF, 88);
    // 1111_1111_0000_0000_1000
    run_load("reload", 8'hFF, 8'h00, 8'h80, 0, 1'b0, 'hFF008, 88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ccff_stream_loader.md
# ccff_stream_loader

Bitstream loader that sits directly upstream of the pre-configured FPGA fabric wrapper. It accepts configuration bytes over a valid/ready byte interface and serializes them MSB-first onto the fabric's configuration chain head. It generates the programming clock and the configuration-set pulse for the chain. When the programmed bit count has been shifted it raises `done`, which the chip top uses to release the fabric's user-design reset.

## Interface

Parameters:
- `BITSTREAM_LEN`, default 1024: total configuration bits to shift, ≥1.
- `CLK_DIV`, default 2: `clk` cycles per `prog_clk` phase (low and high), ≥1.
- `SET_CYCLES`, default 4: `clk` cycles `cfg_set` is held high before loading, ≥1.
- `CNT_W`, default `$clog2(BITSTREAM_LEN+1)`: width of the bit counter.

Ports:
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level-sampled request to begin a load.
- `byte_data` input 8: configuration byte; bit 7 is shifted first.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `ccff_head` output 1: serial configuration data to the chain head.
- `prog_clk` output 1: programming clock to the chain; the fabric captures on its rising edge.
- `cfg_set` output 1: configuration-set pulse to the fabric.
- `busy` output 1: high in every state except IDLE and DONE.
- `done` output 1: the full bitstream has been shifted; held until the next start or reset.

## Operation

- States: IDLE, SET, LOAD, SHIFT_LO, SHIFT_HI, DONE.
- Reset, asynchronous: state goes to IDLE. All outputs and all counters go to 0.
- IDLE or DONE with `start`=1 at an edge:
  - Next state is SET.
  - `done` clears and the bit counter clears.
  - `start` is ignored in all other states.
- SET:
  - `cfg_set`=1 for exactly `SET_CYCLES` cycles, then LOAD.
  - `prog_clk`=0 and `ccff_head`=0 throughout.
- LOAD:
  - `byte_ready`=1, registered and asserted only in this state.
  - A transfer occurs at an edge where `byte_valid` and `byte_ready` are both 1. The byte is latched into an 8-bit shift register, the bit index is set to 7, and the next state is SHIFT_LO.
  - `byte_valid`=0 stalls in LOAD indefinitely. `prog_clk` stays 0.
- SHIFT_LO:
  - `ccff_head` = current bit, driven on entry and stable through the following SHIFT_HI.
  - `prog_clk`=0 for `CLK_DIV` cycles, then SHIFT_HI.
- SHIFT_HI:
  - `prog_clk`=1 for `CLK_DIV` cycles.
  - On exit the bit counter increments (saturating at `BITSTREAM_LEN`).
  - If the counter reaches `BITSTREAM_LEN`, go to DONE.
  - Else, if all 8 bits of the byte are used, go to LOAD.
  - Else shift to the next bit and go to SHIFT_LO.
- Final byte: when `BITSTREAM_LEN` mod 8 ≠ 0, only the top (`BITSTREAM_LEN` mod 8) bits of the final byte are shifted. The remaining bits are discarded, and no extra byte is requested.
- DONE: `done`=1, `busy`=0, `byte_ready`=0, `prog_clk`=0, `ccff_head`=0.
- `cfg_set` is never high while `prog_clk` is toggling.
- No glitch on `prog_clk`: it is a direct flop output.

## Timing

- Every output is registered with no combinational path from inputs.
- `start` accepted at edge N: `busy`=1 and `cfg_set`=1 from N+1 through N+`SET_CYCLES`. `byte_ready`=1 from N+`SET_CYCLES`+1.
- Byte accepted at edge M:
  - `byte_ready`=0 from M+1.
  - Bit 7 appears on `ccff_head` at M+1.
  - First `prog_clk` rise at M+1+`CLK_DIV`.
- Each bit occupies 2·`CLK_DIV` cycles. Head setup and hold relative to the `prog_clk` rise are both ≥`CLK_DIV` cycles.
- A full byte takes 16·`CLK_DIV` cycles. `byte_ready` reasserts on the cycle after the last bit's high phase ends.
- Minimum total load time: `SET_CYCLES` + 1 + ⌈`BITSTREAM_LEN`/8⌉ + 2·`CLK_DIV`·`BITSTREAM_LEN` cycles, with zero stall.
- `done` rises on the cycle after the final high phase; `prog_clk` is 0 on that same cycle.
- `rst_n` low mid-shift: `prog_clk` drops immediately (asynchronously). A partial chain load is abandoned, and a restart requires `start`.

## Test plan

- Reset with `rst_n` held low: all outputs 0. Release `rst_n`, keep `start`=0 for 50 cycles: outputs stay 0, `prog_clk` never toggles.
- `BITSTREAM_LEN`=20, `CLK_DIV`=2, `SET_CYCLES`=4, bytes 0xA5, 0x3C, 0xF0 with `byte_valid` always 1:
  - Chain monitor sampling `ccff_head` on `prog_clk` rises sees 1010_0101_0011_1100_1111, exactly 20 rises.
  - Exactly 3 byte handshakes occur.
  - `done`=1 after 4+1+3+80 cycles.
- Same configuration, with `byte_valid` dropped for 10 cycles before the second byte: `prog_clk` stays 0 and `byte_ready` stays 1 during the stall. The bit sequence is unchanged and `done` arrives 10 cycles later.
- `cfg_set` check: `cfg_set` high for exactly 4 cycles starting one cycle after `start`, with no `prog_clk` edge while it is high. `start` pulses during SHIFT have no effect.
- Drive `rst_n` low during the 2nd byte's SHIFT_HI:
  - `prog_clk`=0 immediately and state is IDLE.
  - After `start` and a fresh 3-byte load, the monitor sees the full correct 20 bits.
- From DONE, assert `start` again: `done` clears on the next cycle, `cfg_set` pulses, and a second bitstream 0xFF, 0x00, 0x80 loads as 1111_1111_0000_0000_1000.
